// File: rtl/alu_multiciclo_n.sv
// alu_multiciclo_n: WIDTH-bit ALU with single-cycle arithmetic/logic/compare
// and iterative unsigned multiply (shift-add) and, when ALU_DIV_EN is
// defined, an iterative restoring divider. A valid/ready handshake holds off
// the requester while an iterative operation runs. Results are registered and
// flagged by a one-cycle valid_o pulse.
// Build option: ALU_DIV_EN enables the divider (opcodes 1010/1011); without it
// those opcodes behave as invalid single-cycle opcodes returning 0.
module alu_multiciclo_n #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [3:0]       operacion_i,
   output logic [WIDTH-1:0] resultado_o,
   output logic             valid_o,
   output logic             zero_o,
   output logic             overflow_o
);

   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
`ifdef ALU_DIV_EN
   localparam logic [1:0] S_DIV  = 2'd2;
`endif

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   // Upper half: partial product / remainder; lower half: multiplier / quotient
   logic [2*WIDTH-1:0] prod_q, prod_d;
   // Multiplicand (MUL) or divisor (DIV), captured at acceptance
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   // Selects high half (MULHU) or remainder (REMU) at completion
   logic               hi_q, hi_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               valid_q, valid_d;
   logic               zero_q, zero_d;
   logic               ovf_q, ovf_d;

   // Shared adder/subtractor: ADD uses a+b, everything else in the
   // single-cycle compare family uses a+~b+1.
   logic             sub;
   logic [WIDTH-1:0] b_op;
   logic [WIDTH:0]   sum;
   logic             ovf_as, slt, sltu;
   assign sub    = (operacion_i != 4'b0000);
   assign b_op   = sub ? ~b_i : b_i;
   assign sum    = {1'b0, a_i} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};
   assign ovf_as = (a_i[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
   assign slt    = sum[WIDTH-1] ^ ovf_as;
   assign sltu   = ~sum[WIDTH];

   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;

   // Single-cycle result selection; unused/invalid opcodes return 0
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (operacion_i)
         4'b0000: begin alu_res = sum[WIDTH-1:0]; alu_ovf = ovf_as; end
         4'b0001: alu_res = a_i & b_i;
         4'b0010: alu_res = a_i | b_i;
         4'b0011: alu_res = a_i ^ b_i;
         4'b0100: begin alu_res = sum[WIDTH-1:0]; alu_ovf = ovf_as; end
         4'b0101: alu_res = {{(WIDTH-1){1'b0}}, slt};
         4'b0110: alu_res = {{(WIDTH-1){1'b0}}, sltu};
         default: alu_res = '0;
      endcase
   end

   // One shift-add step: add multiplicand if LSB of multiplier set, shift right
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                     (prod_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
   assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

`ifdef ALU_DIV_EN
   // One restoring step: shift in next dividend bit, subtract if it fits
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] div_next;
   assign div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
   assign div_ge    = div_shift >= {1'b0, opnd_q};
   assign div_rem   = WIDTH'(div_shift - {1'b0, opnd_q});
   assign div_next  = div_ge ? {div_rem, prod_q[WIDTH-2:0], 1'b1}
                             : {prod_q[2*WIDTH-2:0], 1'b0};
`endif

   // Control FSM: accept in IDLE, iterate MUL/DIV, register results
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      opnd_d  = opnd_q;
      hi_d    = hi_q;
      res_d   = res_q;
      zero_d  = zero_q;
      ovf_d   = ovf_q;
      valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (valid_i) begin
               case (operacion_i)
                  4'b1000, 4'b1001: begin
                     state_d = S_MUL;
                     cnt_d   = CW'(WIDTH-1);
                     prod_d  = {{WIDTH{1'b0}}, b_i};
                     opnd_d  = a_i;
                     hi_d    = operacion_i[0];
                  end
`ifdef ALU_DIV_EN
                  4'b1010, 4'b1011: begin
                     state_d = S_DIV;
                     cnt_d   = CW'(WIDTH-1);
                     prod_d  = {{WIDTH{1'b0}}, a_i};
                     opnd_d  = b_i;
                     hi_d    = operacion_i[0];
                  end
`endif
                  default: begin
                     res_d   = alu_res;
                     ovf_d   = alu_ovf;
                     zero_d  = ~|alu_res;
                     valid_d = 1'b1;
                  end
               endcase
            end
         end
         S_MUL: begin
            prod_d = mul_next;
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               res_d   = hi_q ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
               zero_d  = ~|res_d;
               ovf_d   = 1'b0;
               valid_d = 1'b1;
            end
         end
`ifdef ALU_DIV_EN
         S_DIV: begin
            prod_d = div_next;
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               res_d   = hi_q ? div_next[2*WIDTH-1:WIDTH] : div_next[WIDTH-1:0];
               zero_d  = ~|res_d;
               ovf_d   = 1'b0;
               valid_d = 1'b1;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset aborts any running iteration
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         prod_q  <= '0;
         opnd_q  <= '0;
         hi_q    <= 1'b0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         opnd_q  <= opnd_d;
         hi_q    <= hi_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
      end
   end

   assign ready_o     = (state_q == S_IDLE);
   assign resultado_o = res_q;
   assign valid_o     = valid_q;
   assign zero_o      = zero_q;
   assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_alu_multiciclo_n.sv
// tb_alu_multiciclo_n: directed vectors with literal expectations, plus a
// cycle-level reference model (plain arithmetic) checked every clock.
// Expectations for opcodes 1010/1011 follow the ALU_DIV_EN build option.
module tb_alu_multiciclo_n;
   localparam int W = 32;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          valid_i = 1'b0;
   logic          ready_o;
   logic [W-1:0]  a_i = '0;
   logic [W-1:0]  b_i = '0;
   logic [3:0]    operacion_i = '0;
   logic [W-1:0]  resultado_o;
   logic          valid_o, zero_o, overflow_o;

   alu_multiciclo_n #(.WIDTH(W)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
      .a_i(a_i), .b_i(b_i), .operacion_i(operacion_i),
      .resultado_o(resultado_o), .valid_o(valid_o), .zero_o(zero_o),
      .overflow_o(overflow_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: result, overflow and whether the op is iterative
   function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output bit o, output bit m);
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      r = '0; o = 1'b0; m = 1'b0;
      case (op)
         4'd0: begin r = a + b; o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
         4'd1: r = a & b;
         4'd2: r = a | b;
         4'd3: r = a ^ b;
         4'd4: begin r = a - b; o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
         4'd5: r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
         4'd6: r = (a < b) ? W'(1) : W'(0);
         4'd8: begin r = p[W-1:0];   m = 1'b1; end
         4'd9: begin r = p[2*W-1:W]; m = 1'b1; end
`ifdef ALU_DIV_EN
         4'd10: begin r = (b == '0) ? '1 : a / b; m = 1'b1; end
         4'd11: begin r = (b == '0) ? a  : a % b; m = 1'b1; end
`endif
         default: r = '0;
      endcase
   endfunction

   // Model bookkeeping: edges counted by cyc; expected results queued with due cycle
   int           cyc = 0;
   int           busy_until = 0;
   int           wr = 0;
   int           rd = 0;
   logic [W-1:0] q_res [256];
   bit           q_ovf [256];
   int           q_due [256];
   logic [W-1:0] last_res = '0;
   bit           last_z = 1'b0;
   bit           last_o = 1'b0;

   always @(posedge clk_i) begin : monitor
      logic [W-1:0] r;
      bit o, m;
      if (!rst_ni) begin
         busy_until = 0;
      end else if (valid_i && cyc >= busy_until) begin
         model(operacion_i, a_i, b_i, r, o, m);
         q_res[wr % 256] = r;
         q_ovf[wr % 256] = o;
         q_due[wr % 256] = cyc + (m ? W + 1 : 1);
         if (m) busy_until = cyc + W + 1;
         wr++;
      end
      cyc++;
   end

   always @(negedge clk_i) begin : compare
      if (!rst_ni) begin
         rd = wr;
         last_res = '0; last_z = 1'b0; last_o = 1'b0;
      end else begin
         chkb("model ready", ready_o, cyc >= busy_until);
         if (rd != wr && q_due[rd % 256] == cyc) begin
            chkb("model valid", valid_o, 1'b1);
            last_res = q_res[rd % 256];
            last_z   = (q_res[rd % 256] == '0);
            last_o   = q_ovf[rd % 256];
            rd++;
         end else begin
            chkb("model valid idle", valid_o, 1'b0);
         end
         chk("model result", resultado_o, last_res);
         chkb("model zero", zero_o, last_z);
         chkb("model ovf", overflow_o, last_o);
      end
   end

   task automatic drive(input logic v, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      valid_i = v; operacion_i = op; a_i = a; b_i = b;
   endtask

   // Issue one request and wait (bounded) for its valid_o pulse
   task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input bit ez, input bit eo, input int elat, input bit poke);
      int n, low;
      @(negedge clk_i);
      drive(1'b1, op, a, b);
      @(negedge clk_i);
      valid_i = 1'b0;
      n = 1; low = 0;
      while (!valid_o && n < 100) begin
         if (!ready_o) low++;
         if (poke && n == 5) drive(1'b1, 4'b0000, 32'h1111_1111, 32'h2222_2222);
         if (poke && n == 6) drive(1'b0, 4'b0111, 32'h0, 32'h0);
         @(negedge clk_i);
         n++;
      end
      if (!ready_o) low++;
      chk({name, " latency"}, W'(n), W'(elat));
      chk({name, " ready low cycles"}, W'(low), W'(elat - 1));
      chk({name, " result"}, resultado_o, er);
      chkb({name, " zero"}, zero_o, ez);
      chkb({name, " ovf"}, overflow_o, eo);
   endtask

   initial begin
      #1;
      chk("reset result", resultado_o, '0);
      chkb("reset valid", valid_o, 1'b0);
      chkb("reset zero", zero_o, 1'b0);
      chkb("reset ovf", overflow_o, 1'b0);
      chkb("reset ready", ready_o, 1'b1);
      @(negedge clk_i); @(negedge clk_i);
      #2 rst_ni = 1'b1;

      run_op("ADD ovf", 4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 1, 1'b0);

      // Back-to-back single-cycle ops
      @(negedge clk_i);
      drive(1'b1, 4'b0101, 32'hFFFF_FFFF, 32'h1);
      @(negedge clk_i);
      chkb("b2b SLT valid", valid_o, 1'b1);
      chk("b2b SLT", resultado_o, 32'h1);
      drive(1'b1, 4'b0110, 32'hFFFF_FFFF, 32'h1);
      @(negedge clk_i);
      chkb("b2b SLTU valid", valid_o, 1'b1);
      chk("b2b SLTU", resultado_o, 32'h0);
      drive(1'b1, 4'b0100, 32'h5, 32'h5);
      @(negedge clk_i);
      chkb("b2b SUB valid", valid_o, 1'b1);
      chk("b2b SUB", resultado_o, 32'h0);
      chkb("b2b SUB zero", zero_o, 1'b1);
      valid_i = 1'b0;
      @(negedge clk_i);
      chkb("b2b valid drop", valid_o, 1'b0);

      run_op("AND", 4'b0001, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1'b0, 1, 1'b0);
      run_op("OR", 4'b0010, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1'b0, 1, 1'b0);
      run_op("XOR", 4'b0011, 32'h1234_5678, 32'h1234_5678, 32'h0, 1'b1, 1'b0, 1, 1'b0);
      run_op("SUB ovf", 4'b0100, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1, 1'b0);
      run_op("SLT pos", 4'b0101, 32'h3, 32'h7, 32'h1, 1'b0, 1'b0, 1, 1'b0);
      run_op("OP7", 4'b0111, 32'h5, 32'h6, 32'h0, 1'b1, 1'b0, 1, 1'b0);
      run_op("INV F", 4'b1111, 32'h5, 32'h6, 32'h0, 1'b1, 1'b0, 1, 1'b0);

      run_op("MUL", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, W + 1, 1'b0);
      run_op("MULHU poke", 4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, W + 1, 1'b1);
      run_op("MUL small", 4'b1000, 32'd1234, 32'd5678, 32'd7006652, 1'b0, 1'b0, W + 1, 1'b0);

`ifdef ALU_DIV_EN
      run_op("DIVU", 4'b1010, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, W + 1, 1'b0);
      run_op("REMU", 4'b1011, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, W + 1, 1'b0);
      run_op("DIVU by 0", 4'b1010, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, W + 1, 1'b0);
      run_op("REMU by 0", 4'b1011, 32'd5, 32'd0, 32'd5, 1'b0, 1'b0, W + 1, 1'b0);
`else
      run_op("DIVU off", 4'b1010, 32'd100, 32'd7, 32'd0, 1'b1, 1'b0, 1, 1'b0);
      run_op("REMU off", 4'b1011, 32'd100, 32'd7, 32'd0, 1'b1, 1'b0, 1, 1'b0);
`endif

      // Asynchronous reset in the middle of a multiply
      run_op("ADD pre", 4'b0000, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 1, 1'b0);
      @(negedge clk_i);
      drive(1'b1, 4'b1000, 32'd3, 32'd5);
      @(negedge clk_i);
      valid_i = 1'b0;
      repeat (10) @(negedge clk_i);
      chkb("mid MUL busy", ready_o, 1'b0);
      #2 rst_ni = 1'b0;
      #1;
      chkb("async rst ready", ready_o, 1'b1);
      chkb("async rst valid", valid_o, 1'b0);
      chk("async rst result", resultado_o, '0);
      chkb("async rst zero", zero_o, 1'b0);
      @(negedge clk_i); @(negedge clk_i);
      #2 rst_ni = 1'b1;
      run_op("ADD post", 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1, 1'b0);

      repeat (3) @(negedge clk_i);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
